// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversions.
// Used by the write-side and read-side controllers and the dual-port memory.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned FIFO_PTRW     = FIFO_ADDRSIZE + 1;
  localparam int unsigned FIFO_DEPTH    = 1 << FIFO_ADDRSIZE;

  // Pointer width for a given address size (one wrap bit above the address).
  function automatic int unsigned ptr_width(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

  // Number of memory entries for a given address size.
  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 1 << addrsize;
  endfunction

  // Binary to Gray; callers zero-extend into and truncate out of the 32-bit form.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; zero-extended inputs convert correctly at any narrower width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Generic two-flop synchroniser for Gray-coded pointers crossing clock domains.
module fifo_sync_2ff #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // Plain flop chain; nothing may sit between the two stages.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side controller: write pointer, full/almost-full, level estimate.
// Optional sticky overflow flag (wovf / wovf_clr) when FIFO_WOVF_EN is defined.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel
`ifdef FIFO_WOVF_EN
  ,
  input  logic                wovf_clr,
  output logic                wovf
`endif
);

  localparam int unsigned PW        = ptr_width(ADDRSIZE);
  localparam int unsigned AF_THRESH = fifo_depth(ADDRSIZE) - AFULL_MARGIN;
  // Full pattern: top two Gray bits inverted (both bits when the pointer is 2 wide).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rq_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] lvl_next;

  // Bring the read Gray pointer into wclk.
  fifo_sync_2ff #(
    .WIDTH (PW)
  ) u_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (wq2_rptr),
    .q      (rq_s)
  );

  // Next-pointer, synchronised read position and occupancy after this edge.
  always_comb begin
    wclken    = winc & ~wfull;
    wbinnext  = wbin + PW'(wclken);
    wgraynext = PW'(bin2gray(32'(wbinnext)));
    rbin_s    = PW'(gray2bin(32'(rq_s)));
    lvl_next  = wbinnext - rbin_s;
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Pointer, flag and level registers; flags look at the post-write pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == (rq_s ^ FULL_MASK));
      wafull <= (lvl_next >= PW'(AF_THRESH));
      wlevel <= lvl_next;
    end
  end

`ifdef FIFO_WOVF_EN
  // Sticky overflow: a dropped write sets it, and that beats a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (ADDRSIZE=4, AFULL_MARGIN=2), count-based reference model.
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  localparam int A = 4;
  localparam int W = A + 1;
  localparam int D = 16;

  logic         wclk = 1'b0;
  logic         wrst_n = 1'b1;
  logic         winc = 1'b0;
  logic [A:0]   wq2_rptr = '0;
  logic [A-1:0] waddr;
  logic         wclken;
  logic [A:0]   wptr;
  logic         wfull;
  logic         wafull;
  logic [A:0]   wlevel;
`ifdef FIFO_WOVF_EN
  logic         wovf_clr = 1'b0;
  logic         wovf;
  logic         m_ovf = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  string phase = "init";

  // Reference model: write count, read count seen through two sync stages.
  int   m_wcnt = 0;
  int   m_rs = 0;
  int   m_r1 = 0;
  logic m_full = 1'b0;
  logic m_afull = 1'b0;
  int   rcnt = 0;

  always #5 wclk = ~wclk;

  fifo_wptr_full #(
    .ADDRSIZE     (A),
    .AFULL_MARGIN (2)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .waddr    (waddr),
    .wclken   (wclken),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel)
`ifdef FIFO_WOVF_EN
    ,
    .wovf_clr (wovf_clr),
    .wovf     (wovf)
`endif
  );

  function automatic logic [A:0] gray(input int v);
    logic [A:0] b;
    b = W'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d want %0d", phase, name, act, exp);
    end
  endtask

  // Gray property on the outgoing pointer and the synchroniser output.
  logic [A:0] prev_wptr = '0;
  logic [A:0] prev_rq = '0;
  always @(negedge wclk) begin
    if (!wrst_n) begin
      prev_wptr = '0;
      prev_rq   = '0;
    end else begin
      if (wptr != prev_wptr) chk("gray_wptr", $countones(wptr ^ prev_wptr), 1);
      if (dut.rq_s != prev_rq) chk("gray_sync", $countones(dut.rq_s ^ prev_rq), 1);
      prev_wptr = wptr;
      prev_rq   = dut.rq_s;
    end
  end

  // One wclk cycle: drive, check combinational outputs, clock, update model, check registers.
  task automatic step(input logic w, input int r);
    int lvl;
    winc = w;
    rcnt = r;
    wq2_rptr = gray(r);
    #1;
    chk("wclken", int'(wclken), int'(w & ~m_full));
    chk("waddr", int'(waddr), m_wcnt % D);
    @(posedge wclk);
`ifdef FIFO_WOVF_EN
    if (w && m_full) m_ovf = 1'b1;
    else if (wovf_clr) m_ovf = 1'b0;
`endif
    if (w && !m_full) m_wcnt++;
    lvl     = m_wcnt - m_rs;
    m_rs    = m_r1;
    m_r1    = r;
    m_full  = (lvl == D);
    m_afull = (lvl >= D - 2);
    #1;
    chk("wfull", int'(wfull), int'(m_full));
    chk("wafull", int'(wafull), int'(m_afull));
    chk("wlevel", int'(wlevel), lvl);
    chk("wptr", int'(wptr), int'(gray(m_wcnt)));
`ifdef FIFO_WOVF_EN
    chk("wovf", int'(wovf), int'(m_ovf));
`endif
    @(negedge wclk);
  endtask

  // Mid-cycle asynchronous reset; called at a falling edge.
  task automatic do_reset();
    #2;
    wrst_n = 1'b0;
    winc = 1'b0;
    rcnt = 0;
    wq2_rptr = '0;
    #1;
    chk("rst_wptr", int'(wptr), 0);
    chk("rst_wfull", int'(wfull), 0);
    chk("rst_wafull", int'(wafull), 0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_waddr", int'(waddr), 0);
`ifdef FIFO_WOVF_EN
    chk("rst_wovf", int'(wovf), 0);
    m_ovf = 1'b0;
`endif
    m_wcnt = 0; m_rs = 0; m_r1 = 0; m_full = 1'b0; m_afull = 1'b0;
    @(negedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  typedef struct {
    logic w;
    int   r;
    logic e_clken;
    logic e_full;
    logic e_afull;
    int   e_lvl;
    int   e_ptr;
  } vec_t;

  vec_t fill [17];

  initial begin
    // 16 writes fill the FIFO, the 17th is refused.
    for (int i = 0; i < 17; i++) begin
      int n;
      n = (i < 16) ? i + 1 : 16;
      fill[i] = '{1'b1, 0, (i < 16), (n == 16), (n >= 14), n, int'(gray(n))};
    end

    @(negedge wclk);
    phase = "reset";
    do_reset();

    phase = "fill";
    for (int i = 0; i < 17; i++) begin
      winc = fill[i].w;
      wq2_rptr = gray(fill[i].r);
      #1;
      chk("tbl_clken", int'(wclken), int'(fill[i].e_clken));
      step(fill[i].w, fill[i].r);
      chk("tbl_full", int'(wfull), int'(fill[i].e_full));
      chk("tbl_afull", int'(wafull), int'(fill[i].e_afull));
      chk("tbl_lvl", int'(wlevel), fill[i].e_lvl);
      chk("tbl_ptr", int'(wptr), fill[i].e_ptr);
    end
    chk("full_ptr_11000", int'(wptr), 24);

`ifdef FIFO_WOVF_EN
    phase = "ovf";
    wovf_clr = 1'b1;
    step(1'b0, 0);
    chk("ovf_clr_alone", int'(wovf), 0);
    wovf_clr = 1'b0;
    step(1'b1, 0);
    chk("ovf_set", int'(wovf), 1);
    step(1'b0, 0);
    chk("ovf_sticky", int'(wovf), 1);
    wovf_clr = 1'b1;
    step(1'b1, 0);
    chk("ovf_set_wins", int'(wovf), 1);
    step(1'b0, 0);
    chk("ovf_cleared", int'(wovf), 0);
    wovf_clr = 1'b0;
`endif

    phase = "drain";
    step(1'b0, 1);
    chk("drain_still_full", int'(wfull), 1);
    step(1'b0, 1);
    step(1'b0, 1);
    chk("drain_full_off", int'(wfull), 0);
    chk("drain_lvl15", int'(wlevel), 15);
    chk("drain_afull_on", int'(wafull), 1);
    step(1'b0, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 3);
    chk("drain_afull_off", int'(wafull), 0);

    phase = "midreset";
    do_reset();

    phase = "wrap";
    for (int i = 0; i < 40; i++) begin
      chk("wrap_waddr", int'(waddr), i % 16);
      step(1'b1, (i >= 2) ? i - 2 : 0);
      chk("wrap_msb", int'(wptr[A]), ((i + 1) / 16) % 2);
      chk("wrap_nofull", int'(wfull), 0);
    end

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic w;
      int   wr;
      int   rr;
      wr = (i < 200) ? 7 : 3;
      rr = (i < 200) ? 4 : 8;
      w  = ($urandom_range(0, 9) < wr);
      if (rcnt < m_wcnt && $urandom_range(0, 9) < rr) rcnt++;
      step(w, rcnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
